// File: rtl/gpio_ctrl.sv
// Wishbone-mapped GPIO controller: output register with set/clear aliases,
// synchronised inputs, per-pin edge capture into sticky W1C status and a
// level interrupt towards the CPU.
module gpio_ctrl #(
    parameter int unsigned WIDTH       = 22,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [31:0]      wb_adr,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_we,
    input  logic [3:0]       wb_sel,
    input  logic             wb_stb,
    input  logic             wb_cyc,
    output logic             wb_ack,
    output logic [WIDTH-1:0] gpio_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic             irq
);

    localparam logic [2:0] AddrOut    = 3'd0;
    localparam logic [2:0] AddrIn     = 3'd1;
    localparam logic [2:0] AddrRiseEn = 3'd2;
    localparam logic [2:0] AddrFallEn = 3'd3;
    localparam logic [2:0] AddrStatus = 3'd4;
    localparam logic [2:0] AddrOutSet = 3'd5;
    localparam logic [2:0] AddrOutClr = 3'd6;

    // Register state
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;

    // Input path state
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;

    // Bus state
    logic        ack_q;
    logic [31:0] dat_q, dat_d;
    logic        req;
    logic        wr;
    logic [2:0]  adr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] bmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0] rdata;

    // Address and data bits outside the decoded range are deliberately ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_adr[31:5], wb_adr[1:0], wb_dat_i, wb_sel};

    // A request is only taken when no ack is outstanding, so ack is a
    // one-cycle pulse and back-to-back requests complete every 2 cycles.
    assign req   = wb_cyc & wb_stb & ~ack_q;
    assign wr    = req & wb_we;
    assign adr   = wb_adr[4:2];
    assign wdata = wb_dat_i[WIDTH-1:0];

    // Expand byte enables to a per-pin write mask.
    always_comb begin
        bmask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bmask[i] = wb_sel[i >> 3];
        end
    end

    assign wbits = wdata & bmask;

    // Edge detection on the synchronised input.
    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

    // Synchroniser chain and previous-value flop for edge detection.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            prev_q <= sync;
        end
    end

    // Register write decode; unselected bytes keep their old value.
    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        if (wr) begin
            case (adr)
                AddrOut:    out_d     = (out_q & ~bmask) | wbits;
                AddrRiseEn: rise_en_d = (rise_en_q & ~bmask) | wbits;
                AddrFallEn: fall_en_d = (fall_en_q & ~bmask) | wbits;
                AddrStatus: w1c_mask  = wbits;
                AddrOutSet: out_d     = out_q | wbits;
                AddrOutClr: out_d     = out_q & ~wbits;
                default:    ;
            endcase
        end
    end

    // Sticky status: a fresh edge overrides a same-cycle clear of that bit.
    always_comb begin
        status_d = (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Read mux; write-only and unmapped locations read 0.
    always_comb begin
        rdata = '0;
        case (adr)
            AddrOut:    rdata[WIDTH-1:0] = out_q;
            AddrIn:     rdata[WIDTH-1:0] = sync;
            AddrRiseEn: rdata[WIDTH-1:0] = rise_en_q;
            AddrFallEn: rdata[WIDTH-1:0] = fall_en_q;
            AddrStatus: rdata[WIDTH-1:0] = status_q;
            default:    rdata = '0;
        endcase
    end

    // Read data is only driven alongside the ack of a read.
    always_comb begin
        dat_d = (req && !wb_we) ? rdata : '0;
    end

    // Register file and bus response flops.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ack_q     <= req;
            dat_q     <= dat_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_o   = out_q;
    assign irq      = |(status_q & (rise_en_q | fall_en_q));

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus a randomized
// sequence checked against a register-level behavioural model.
module tb_gpio_ctrl;

    localparam int unsigned WIDTH = 22;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [WIDTH-1:0] ALL = 22'h3FFFFF;

    logic             clk;
    logic             arstn;
    logic [31:0]      wb_adr;
    logic [31:0]      wb_dat_i;
    logic [31:0]      wb_dat_o;
    logic             wb_we;
    logic [3:0]       wb_sel;
    logic             wb_stb;
    logic             wb_cyc;
    logic             wb_ack;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] gpio_i;
    logic             irq;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the programmer-visible state.
    logic [WIDTH-1:0] m_out, m_ren, m_fen, m_stat, m_pad;

    gpio_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .arstn    (arstn),
        .wb_adr   (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .gpio_o   (gpio_o),
        .gpio_i   (gpio_i),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] sel_mask(input logic [3:0] sel);
        return {(sel[2] ? 6'h3F : 6'h00), (sel[1] ? 8'hFF : 8'h00), (sel[0] ? 8'hFF : 8'h00)};
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            0: v[WIDTH-1:0] = m_out;
            1: v[WIDTH-1:0] = m_pad;
            2: v[WIDTH-1:0] = m_ren;
            3: v[WIDTH-1:0] = m_fen;
            4: v[WIDTH-1:0] = m_stat;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic model_irq();
        return |(m_stat & (m_ren | m_fen));
    endfunction

    // Apply a bus write to the model.
    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] sel);
        logic [WIDTH-1:0] bits, mask;
        mask = sel_mask(sel);
        bits = d[WIDTH-1:0] & mask;
        case (a)
            0: m_out = (m_out & ~mask) | bits;
            2: m_ren = (m_ren & ~mask) | bits;
            3: m_fen = (m_fen & ~mask) | bits;
            4: m_stat = m_stat & ~bits;
            5: m_out = m_out | bits;
            6: m_out = m_out & ~bits;
            default: ;
        endcase
    endtask

    // Single Wiishbone transaction; the ack must appear right after the request edge.
    task automatic bus(input logic we, input int a, input logic [31:0] d, input logic [3:0] sel,
                       output logic [31:0] rd);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = 32'(a) << 2; wb_dat_i = d; wb_sel = sel;
        @(posedge clk); #1;
        checks++;
        if (wb_ack !== 1'b1) begin
            failures++;
            $display("FAIL bus_ack adr=%0d got=%b want=1", a, wb_ack);
        end
        rd = wb_dat_o;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] rd;
        bus(1'b1, a, d, sel, rd);
        model_write(a, d, sel);
    endtask

    task automatic rd_reg(input int a, output logic [31:0] d);
        bus(1'b0, a, 32'd0, 4'hF, d);
    endtask

    // Change pads and let the edges settle through the synchroniser.
    task automatic set_pads(input logic [WIDTH-1:0] v);
        @(negedge clk);
        gpio_i = v;
        m_stat = m_stat | ((v & ~m_pad) & m_ren) | ((~v & m_pad) & m_fen);
        m_pad = v;
        repeat (SYNC_STAGES + 3) @(posedge clk);
    endtask

    task automatic model_reset();
        m_out = '0; m_ren = '0; m_fen = '0; m_stat = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        arstn = 1'b0;
        gpio_i = ALL;
        m_pad = ALL;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gpio_o !== '0 || irq !== 1'b0 || wb_ack !== 1'b0 || wb_dat_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs gpio_o=%h irq=%b ack=%b dat=%h want all 0",
                     gpio_o, irq, wb_ack, wb_dat_o);
        end
        @(negedge clk);
        arstn = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        for (int a = 0; a < 8; a++) begin
            rd_reg(a, d);
            checks++;
            if (d !== model_read(a)) begin
                failures++;
                $display("FAIL reset_read adr=%0d got=%h want=%h", a, d, model_read(a));
            end
        end
        checks++;
        if (irq !== 1'b0 || gpio_o !== '0) begin
            failures++;
            $display("FAIL reset_irq irq=%b gpio_o=%h want 0", irq, gpio_o);
        end
    endtask

    task automatic test_out_set_clr();
        logic [31:0] d;
        wr(0, 32'h00F0F0, 4'hF);
        wr(5, 32'h000003, 4'hF);
        wr(6, 32'h000010, 4'hF);
        rd_reg(0, d);
        checks++;
        if (gpio_o !== 22'h00F0E3 || d !== 32'h00F0E3) begin
            failures++;
            $display("FAIL out_set_clr gpio_o=%h read=%h want=00f0e3", gpio_o, d);
        end
        rd_reg(5, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL out_set_read got=%h want=0", d);
        end
        wr(0, 32'hFFFFFFFF, 4'b0001);
        rd_reg(0, d);
        checks++;
        if (gpio_o !== 22'h00F0FF || d !== 32'h00F0FF) begin
            failures++;
            $display("FAIL out_bytesel gpio_o=%h read=%h want=00f0ff", gpio_o, d);
        end
    endtask

    task automatic test_edge_capture();
        logic [31:0] d;
        set_pads(22'h000002);
        wr(2, 32'h1, 4'hF);
        wr(3, 32'h2, 4'hF);
        wr(4, 32'h3FFFFF, 4'hF);
        // Pin 0 rises and pin 1 falls; status lands one cycle after sync output.
        @(negedge clk);
        gpio_i = 22'h000001;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL edge_early irq=%b want=0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL edge_latency irq=%b want=1", irq);
        end
        m_stat = m_stat | 22'h3;
        m_pad = 22'h000001;
        rd_reg(4, d);
        checks++;
        if (d !== 32'h3) begin
            failures++;
            $display("FAIL edge_status got=%h want=3", d);
        end
        set_pads(22'h000005);
        rd_reg(4, d);
        checks++;
        if (d !== model_read(4)) begin
            failures++;
            $display("FAIL edge_disabled got=%h want=%h", d, model_read(4));
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        set_pads(22'h000004);
        wr(4, 32'h3FFFFF, 4'hF);
        // Rise on pin 0 reaches the detector exactly when the W1C request is taken.
        @(negedge clk);
        gpio_i = 22'h000005;
        m_pad = 22'h000005;
        @(posedge clk);
        @(posedge clk);
        wr(4, 32'h1, 4'hF);
        m_stat = m_stat | 22'h1;
        rd_reg(4, d);
        checks++;
        if (d[0] !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_race status=%h irq=%b want bit0=1 irq=1", d, irq);
        end
        wr(4, 32'h1, 4'hF);
        rd_reg(4, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_clear status=%h irq=%b want 0 0", d, irq);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, data;
        int a, op;
        logic [3:0] sel;
        int addrs[6] = '{0, 2, 3, 4, 5, 6};
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                set_pads(WIDTH'($urandom));
            end else begin
                a = addrs[$urandom_range(0, 5)];
                data = $urandom;
                sel = 4'($urandom);
                wr(a, data, sel);
            end
            a = int'($urandom_range(0, 7));
            rd_reg(a, d);
            checks++;
            if (d !== model_read(a) || gpio_o !== m_out || irq !== model_irq()) begin
                failures++;
                $display("FAIL random it=%0d adr=%0d read=%h/%h gpio_o=%h/%h irq=%b/%b",
                         it, a, d, model_read(a), gpio_o, m_out, irq, model_irq());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        logic [31:0] d;
        pat = '0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'd0; wb_sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[5-i] = wb_ack;
            if (wb_ack === 1'b0) begin
                checks++;
                if (wb_dat_o !== 32'd0) begin
                    failures++;
                    $display("FAIL idle_dat cycle=%0d got=%h want=0", i, wb_dat_o);
                end
            end
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        checks++;
        if (pat !== 6'b101010) begin
            failures++;
            $display("FAIL b2b_ack got=%b want=101010", pat);
        end
        rd_reg(7, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL addr7 got=%h want=0", d);
        end
        wr(1, 32'h0, 4'hF);
        rd_reg(1, d);
        checks++;
        if (d !== model_read(1)) begin
            failures++;
            $display("FAIL in_write got=%h want=%h", d, model_read(1));
        end
    endtask

    task automatic test_reset_in_ack();
        logic [31:0] d;
        wr(2, 32'h3FFFFF, 4'hF);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 32'd0; wb_dat_i = 32'h123456; wb_sel = 4'hF;
        @(posedge clk); #1;
        arstn = 1'b0;
        #1;
        checks++;
        if (wb_ack !== 1'b0 || gpio_o !== '0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack ack=%b gpio_o=%h irq=%b want 0", wb_ack, gpio_o, irq);
        end
        model_reset();
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        for (int a = 0; a < 5; a++) begin
            rd_reg(a, d);
            checks++;
            if (d !== model_read(a)) begin
                failures++;
                $display("FAIL reset_ack_read adr=%0d got=%h want=%h", a, d, model_read(a));
            end
        end
    endtask

    initial begin
        wb_adr = '0; wb_dat_i = '0; wb_we = 1'b0; wb_sel = '0;
        wb_stb = 1'b0; wb_cyc = 1'b0;
        test_reset();
        test_out_set_clr();
        test_edge_capture();
        test_w1c_race();
        test_random();
        test_back_to_back();
        test_reset_in_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
